// File: rtl/fetch_queue_pkg.sv
// Types and constants shared by the fetch queue and its FIFO.
// No logic, no latency.
// No flow control of its own.
package fetch_queue_pkg;

`include "fetch_queue_defs.v"

  typedef enum logic [1:0] {
    ST_FETCH = `S_FETCH,
    ST_WAIT  = `S_WAIT,
    ST_DROP  = `S_DROP
  } fq_state_t;

  localparam int          WORD_BYTES       = `WORD_BYTES;
  localparam logic [31:0] RESET_PC_DEFAULT = `RESET_PC_DEFAULT;

endpackage

// File: rtl/fetch_queue_defs.v
// Shared encodings and defaults for the fetch queue.
// Pure `define file, no logic, no latency.
// Guarded so that multiple inclusion is harmless.
`ifndef FETCH_QUEUE_DEFS_V
`define FETCH_QUEUE_DEFS_V

`define S_FETCH 2'd0
`define S_WAIT  2'd1
`define S_DROP  2'd2

`define RESET_PC_DEFAULT 32'h0000_3000

`define WORD_BYTES 4

`endif

// File: rtl/fq_fifo.sv
// DEPTH-entry FIFO of {pc, inst} pairs with synchronous clear.
// Push visible at the head one cycle later, head is read combinationally.
// Push is dropped when full without a pop; pop when empty has no effect.
module fq_fifo #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_inst,
  input  logic            pop,
  output logic [CW-1:0]   count,
  output logic [XLEN-1:0] head_data,
  output logic [XLEN-1:0] head_pc
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !clear && (count != '0);
  assign do_push = push && !clear && ((count != FULL) || do_pop);

  assign {head_pc, head_data} = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_pc, push_inst};
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues word reads, queues {pc, inst} for decode.
// One request outstanding; next request can issue on the edge that accepts a response.
// Issue stalls while the queue has no room for the response; redirect flushes and refetches.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(WORD_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(WORD_BYTES - 1);

  fq_state_t       state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            issue;

  assign inst_valid = (count != '0);
  // A redirect both drops the coincident response and blocks the coincident pop.
  assign pop  = inst_valid && inst_ready && !redirect_valid;
  assign push = (state == ST_WAIT) && imem_valid && !redirect_valid;

  // Decide whether a new request goes out on this edge; room accounts for the
  // push and pop happening on the same edge so a response never finds the queue full.
  always_comb begin
    issue = 1'b0;
    case (state)
      ST_FETCH: issue = (count < DEPTH_C);
      ST_WAIT:  issue = imem_valid && ((count < DEPTH_M1) || pop);
      ST_DROP:  issue = imem_valid && (count < DEPTH_C);
      default:  issue = 1'b0;
    endcase
    if (redirect_valid) issue = 1'b0;
  end

  // Fetch FSM, PC and request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      imem_req <= issue;
      if (issue) begin
        imem_addr <= fetch_pc;
        req_pc    <= fetch_pc;
        fetch_pc  <= fetch_pc + STEP;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~LOW_MASK;
        // A response still in flight must be swallowed; one arriving now is already gone.
        state <= ((state != ST_FETCH) && !imem_valid) ? ST_DROP : ST_FETCH;
      end else begin
        case (state)
          ST_FETCH: if (issue) state <= ST_WAIT;
          ST_WAIT,
          ST_DROP:  if (imem_valid) state <= issue ? ST_WAIT : ST_FETCH;
          default:  state <= ST_FETCH;
        endcase
      end
    end
  end

  fq_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_pc   (req_pc),
    .push_inst (imem_rdata),
    .pop       (pop),
    .count     (count),
    .head_data (inst_data),
    .head_pc   (inst_pc)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: variable-latency memory model plus request/delivery scoreboard.
// Stimulus and checks run mid-cycle, away from the rising edge.
// Decode backpressure is driven directly through inst_ready.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_tests = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          mem_left = 0;
  logic [31:0] mem_addr = '0;
  int          req_count = 0;
  int          pop_count = 0;
  int          snap;
  logic [31:0] exp_next = 32'h0000_3000;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out after 50 cycles", name);
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!imem_req && k < 50) begin
      tick();
      k++;
    end
    if (!imem_req) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!imem_valid && k < 50) begin
      tick();
      k++;
    end
    if (!imem_valid) timeout(name);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Instruction memory: one response per request, lat cycles later.
  initial forever begin
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (!reset) begin
      mem_left = 0;
    end else begin
      if (mem_left > 0) begin
        mem_left--;
        if (mem_left == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_addr);
        end
      end
      if (imem_req) begin
        mem_left = lat;
        mem_addr = imem_addr;
      end
    end
  end

  // Monitor: request addresses follow the modelled PC; deliveries pop the scoreboard.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!reset) begin
      exp_q.delete();
      exp_next = RST_PC;
    end else begin
      if (imem_req) begin
        req_count++;
        check("req_addr", imem_addr, exp_next);
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h, want no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_data", inst_data, mem_word(e));
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_next = redirect_pc & ~32'd3;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_fetch_pc", dut.fetch_pc, 32'h0000_3000);

    // 1: streaming at latency 1, decode always ready
    lat = 1;
    inst_ready = 1'b1;
    pop_count = 0;
    reset = 1'b1;
    repeat (40) tick();
    check("t1_pops_ge_15", pop_count >= 15, 1);

    // 2: decode stalled, queue fills after exactly DEPTH requests
    do_reset();
    lat = 1;
    req_count = 0;
    repeat (20) tick();
    check("t2_req_count", req_count, 4);
    check("t2_req_idle", imem_req, 0);
    check("t2_inst_valid", inst_valid, 1);
    check("t2_count", dut.count, 4);
    check("t2_head_pc", inst_pc, 32'h0000_3000);
    pop_count = 0;
    inst_ready = 1'b1;
    repeat (20) tick();
    check("t2_resume_pops_ge_6", pop_count >= 6, 1);

    // 3: redirect while waiting at latency 3
    do_reset();
    lat = 3;
    inst_ready = 1'b1;
    tick();
    wait_req("t3_first_req");
    redirect_pc = 32'h0000_3107;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t3_inst_valid_after_redir", inst_valid, 0);
    check("t3_no_req_while_drop", imem_req, 0);
    wait_valid("t3_dropped_valid");
    tick();
    check("t3_req_after_drop", imem_req, 1);
    check("t3_addr_after_drop", imem_addr, 32'h0000_3104);
    check("t3_dropped_not_queued", inst_valid, 0);
    snap = pop_count;
    repeat (12) tick();
    check("t3_target_delivered", pop_count > snap, 1);

    // 4: redirect coincident with a response and a pop
    do_reset();
    lat = 1;
    tick();
    wait_valid("t4_valid1");
    tick();
    wait_valid("t4_valid2");
    tick();
    wait_valid("t4_valid3");
    inst_ready = 1'b1;
    redirect_pc = 32'h0000_4000;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t4_inst_valid", inst_valid, 0);
    check("t4_count", dut.count, 0);
    check("t4_no_req_yet", imem_req, 0);
    tick();
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h0000_4000);
    repeat (10) tick();

    // 5: PC wraps past the top of the address space
    reset = 1'b0;
    inst_ready = 1'b0;
    repeat (2) tick();
    lat = 1;
    reset = 1'b1;
    inst_ready = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t5_no_req_on_redirect", imem_req, 0);
    tick();
    check("t5_req", imem_req, 1);
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    wait_req("t5_second_req");
    check("t5_addr_wrap", imem_addr, 32'h0000_0000);
    repeat (10) tick();

    // 6: async reset while waiting with 3 entries queued
    do_reset();
    lat = 3;
    tick();
    for (int i = 0; i < 3; i++) begin
      wait_valid("t6_fill");
      tick();
    end
    wait_req("t6_fourth_req");
    check("t6_count_before", dut.count, 3);
    #1;
    reset = 1'b0;
    #1;
    check("t6_inst_valid", inst_valid, 0);
    check("t6_imem_req", imem_req, 0);
    check("t6_imem_addr", imem_addr, 0);
    check("t6_fetch_pc", dut.fetch_pc, 32'h0000_3000);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    wait_req("t6_req_after_reset");
    check("t6_addr_after_reset", imem_addr, 32'h0000_3000);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
